// File: rtl/cm3_out_stage_rr_param.sv
`default_nettype none
// ============================================================================
// cm3_out_stage_rr_param : AHB bus-matrix output stage, NUM_PORTS -> 1 slave
// Revision 1.0
// ============================================================================
module cm3_out_stage_rr_param #(
  parameter int NUM_PORTS = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int ARB_MODE  = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NUM_PORTS-1:0]    sel_i,
  input  logic [NUM_PORTS-1:0]    held_tran_i,
  input  logic [NUM_PORTS*AW-1:0] addr_i,
  input  logic [NUM_PORTS*AW-1:0] auser_i,
  input  logic [NUM_PORTS*2-1:0]  trans_i,
  input  logic [NUM_PORTS-1:0]    write_i,
  input  logic [NUM_PORTS*3-1:0]  size_i,
  input  logic [NUM_PORTS*3-1:0]  burst_i,
  input  logic [NUM_PORTS*4-1:0]  prot_i,
  input  logic [NUM_PORTS*4-1:0]  master_i,
  input  logic [NUM_PORTS-1:0]    mastlock_i,
  input  logic [NUM_PORTS*DW-1:0] wdata_i,
  input  logic [NUM_PORTS*DW-1:0] wuser_i,
  input  logic                    HREADYOUTM,
  output logic [NUM_PORTS-1:0]    active_o,
  output logic                    HSELM,
  output logic [AW-1:0]           HADDRM,
  output logic [AW-1:0]           HAUSERM,
  output logic [1:0]              HTRANSM,
  output logic                    HWRITEM,
  output logic [2:0]              HSIZEM,
  output logic [2:0]              HBURSTM,
  output logic [3:0]              HPROTM,
  output logic [3:0]              HMASTERM,
  output logic                    HMASTLOCKM,
  output logic [DW-1:0]           HWDATAM,
  output logic [DW-1:0]           HWUSERM,
  output logic                    HREADYMUXM
);

  localparam int         c_IW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [1:0] c_TRANS_BUSY = 2'b01;
  localparam logic [1:0] c_TRANS_SEQ  = 2'b11;

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_hold;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] dport_q;
  logic [c_IW-1:0]      last_q, last_d;
  logic                 slave_sel_q;
  logic                 hsel_lock_q, hsel_lock_d;

  assign w_req      = held_tran_i & sel_i;
  assign active_o   = grant_q;
  assign HREADYMUXM = slave_sel_q ? HREADYOUTM : 1'b1;

  // Address phase follows the current grant; an unselected owner presents IDLE.
  always_comb begin
    HSELM      = 1'b0;
    HADDRM     = '0;
    HAUSERM    = '0;
    HTRANSM    = 2'b00;
    HWRITEM    = 1'b0;
    HSIZEM     = 3'b000;
    HBURSTM    = 3'b000;
    HPROTM     = 4'b0000;
    HMASTERM   = 4'b0000;
    HMASTLOCKM = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        HSELM      = sel_i[p];
        HADDRM     = addr_i[p*AW +: AW];
        HAUSERM    = auser_i[p*AW +: AW];
        HTRANSM    = sel_i[p] ? trans_i[p*2 +: 2] : 2'b00;
        HWRITEM    = write_i[p];
        HSIZEM     = size_i[p*3 +: 3];
        HBURSTM    = burst_i[p*3 +: 3];
        HPROTM     = prot_i[p*4 +: 4];
        HMASTERM   = master_i[p*4 +: 4];
        HMASTLOCKM = mastlock_i[p];
      end
    end
  end

  always_comb begin
    HWDATAM = '0;
    HWUSERM = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (dport_q[p]) begin
        HWDATAM = wdata_i[p*DW +: DW];
        HWUSERM = wuser_i[p*DW +: DW];
      end
    end
  end

  // Locked sequences and mid-burst beats keep the current owner.
  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    grant_d = grant_q;
    last_d  = last_q;
    w_hold  = (|grant_q) &
              ((HMASTLOCKM & (hsel_lock_q | HSELM)) |
               (HTRANSM == c_TRANS_BUSY) | (HTRANSM == c_TRANS_SEQ));
    if (!w_hold) begin
      grant_d = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = (ARB_MODE == 0) ? ((int'(last_q) + 1 + k) % NUM_PORTS) : k;
        if (!found && w_req[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          last_d       = c_IW'(idx);
        end
      end
    end
  end

  always_comb begin
    hsel_lock_d = hsel_lock_q;
    if (HSELM & HTRANSM[1] & HMASTLOCKM) begin
      hsel_lock_d = 1'b1;
    end else if (!HMASTLOCKM) begin
      hsel_lock_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q     <= '0;
      last_q      <= c_IW'(NUM_PORTS - 1);
      dport_q     <= '0;
      slave_sel_q <= 1'b0;
      hsel_lock_q <= 1'b0;
    end else if (HREADYMUXM) begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      dport_q     <= grant_q;
      slave_sel_q <= HSELM;
      hsel_lock_q <= hsel_lock_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cm3_out_stage_rr_param.sv
`default_nettype none
// ============================================================================
// tb_cm3_out_stage_rr_param : round-robin and fixed-priority instances vs model
// Revision 1.0
// ============================================================================
module tb_cm3_out_stage_rr_param;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  // per-port stimulus
  logic          p_sel[N], p_held[N], p_write[N], p_lock[N];
  logic [AW-1:0] p_addr[N], p_auser[N];
  logic [1:0]    p_trans[N];
  logic [2:0]    p_size[N], p_burst[N];
  logic [3:0]    p_prot[N], p_master[N];
  logic [DW-1:0] p_wdata[N], p_wuser[N];
  logic          hreadyout;

  logic [N-1:0]    sel_v, held_v, write_v, lock_v;
  logic [N*AW-1:0] addr_v, auser_v;
  logic [N*2-1:0]  trans_v;
  logic [N*3-1:0]  size_v, burst_v;
  logic [N*4-1:0]  prot_v, master_v;
  logic [N*DW-1:0] wdata_v, wuser_v;

  always_comb begin
    sel_v = '0; held_v = '0; write_v = '0; lock_v = '0;
    addr_v = '0; auser_v = '0; trans_v = '0; size_v = '0; burst_v = '0;
    prot_v = '0; master_v = '0; wdata_v = '0; wuser_v = '0;
    for (int p = 0; p < N; p++) begin
      sel_v[p] = p_sel[p]; held_v[p] = p_held[p];
      write_v[p] = p_write[p]; lock_v[p] = p_lock[p];
      addr_v[p*AW +: AW] = p_addr[p]; auser_v[p*AW +: AW] = p_auser[p];
      trans_v[p*2 +: 2] = p_trans[p];
      size_v[p*3 +: 3] = p_size[p]; burst_v[p*3 +: 3] = p_burst[p];
      prot_v[p*4 +: 4] = p_prot[p]; master_v[p*4 +: 4] = p_master[p];
      wdata_v[p*DW +: DW] = p_wdata[p]; wuser_v[p*DW +: DW] = p_wuser[p];
    end
  end

  // index 0 = round-robin instance, 1 = fixed-priority instance
  logic [N-1:0]  d_act[2];
  logic          d_hsel[2], d_write[2], d_lock[2], d_rdy[2];
  logic [AW-1:0] d_addr[2], d_auser[2];
  logic [1:0]    d_trans[2];
  logic [2:0]    d_size[2], d_burst[2];
  logic [3:0]    d_prot[2], d_master[2];
  logic [DW-1:0] d_wdata[2], d_wuser[2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    cm3_out_stage_rr_param #(.NUM_PORTS(N), .AW(AW), .DW(DW), .ARB_MODE(m)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .sel_i(sel_v), .held_tran_i(held_v), .addr_i(addr_v), .auser_i(auser_v),
      .trans_i(trans_v), .write_i(write_v), .size_i(size_v), .burst_i(burst_v),
      .prot_i(prot_v), .master_i(master_v), .mastlock_i(lock_v),
      .wdata_i(wdata_v), .wuser_i(wuser_v), .HREADYOUTM(hreadyout),
      .active_o(d_act[m]), .HSELM(d_hsel[m]), .HADDRM(d_addr[m]), .HAUSERM(d_auser[m]),
      .HTRANSM(d_trans[m]), .HWRITEM(d_write[m]), .HSIZEM(d_size[m]), .HBURSTM(d_burst[m]),
      .HPROTM(d_prot[m]), .HMASTERM(d_master[m]), .HMASTLOCKM(d_lock[m]),
      .HWDATAM(d_wdata[m]), .HWUSERM(d_wuser[m]), .HREADYMUXM(d_rdy[m])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // behavioural model: owner/data-owner as port numbers, -1 meaning nobody
  int   m_own[2], m_last[2], m_dp[2], n_own[2], n_last[2], n_dp[2];
  logic m_ssel[2], m_hl[2], n_ssel[2], n_hl[2];

  logic [N-1:0]  e_act[2];
  logic          e_hsel[2], e_write[2], e_lock[2], e_rdy[2];
  logic [AW-1:0] e_addr[2], e_auser[2];
  logic [1:0]    e_trans[2];
  logic [2:0]    e_size[2], e_burst[2];
  logic [3:0]    e_prot[2], e_master[2];
  logic [DW-1:0] e_wdata[2], e_wuser[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1; m_last[m] = N - 1; m_dp[m] = -1; m_ssel[m] = 1'b0; m_hl[m] = 1'b0;
    end
  endtask

  task automatic model_eval(input int m);
    int o;
    o = m_own[m];
    e_act[m] = '0; e_hsel[m] = 1'b0; e_trans[m] = 2'b00; e_write[m] = 1'b0;
    e_size[m] = '0; e_burst[m] = '0; e_prot[m] = '0; e_master[m] = '0;
    e_lock[m] = 1'b0; e_addr[m] = '0; e_auser[m] = '0;
    if (o >= 0) begin
      e_act[m][o] = 1'b1;
      e_hsel[m]   = p_sel[o];
      e_trans[m]  = p_sel[o] ? p_trans[o] : 2'b00;
      e_write[m]  = p_write[o];
      e_size[m]   = p_size[o];  e_burst[m]  = p_burst[o];
      e_prot[m]   = p_prot[o];  e_master[m] = p_master[o];
      e_lock[m]   = p_lock[o];
      e_addr[m]   = p_addr[o];  e_auser[m]  = p_auser[o];
    end
    e_wdata[m] = '0; e_wuser[m] = '0;
    if (m_dp[m] >= 0) begin
      e_wdata[m] = p_wdata[m_dp[m]];
      e_wuser[m] = p_wuser[m_dp[m]];
    end
    e_rdy[m] = m_ssel[m] ? hreadyout : 1'b1;
  endtask

  task automatic model_next(input int m);
    bit hold;
    int win;
    n_own[m] = m_own[m]; n_last[m] = m_last[m]; n_dp[m] = m_dp[m];
    n_ssel[m] = m_ssel[m]; n_hl[m] = m_hl[m];
    if (e_rdy[m]) begin
      hold = (m_own[m] >= 0) &&
             ((e_lock[m] && (m_hl[m] || e_hsel[m])) || e_trans[m] == 2'b01 || e_trans[m] == 2'b11);
      if (!hold) begin
        win = -1;
        for (int k = 0; k < N; k++) begin
          int p;
          p = (m == 0) ? (m_last[m] + 1 + k) % N : k;
          if (win < 0 && p_held[p] && p_sel[p]) win = p;
        end
        n_own[m] = win;
        if (win >= 0) n_last[m] = win;
      end
      n_dp[m]   = m_own[m];
      n_ssel[m] = e_hsel[m];
      if (e_hsel[m] && e_trans[m][1] && e_lock[m]) n_hl[m] = 1'b1;
      else if (!e_lock[m]) n_hl[m] = 1'b0;
    end
  endtask

  task automatic cmp_model(input int m);
    string t;
    t = (m == 0) ? "rr" : "fx";
    chk({t, "_ctrl"},
        64'({d_act[m], d_hsel[m], d_trans[m], d_write[m], d_size[m], d_burst[m],
             d_prot[m], d_master[m], d_lock[m], d_rdy[m]}),
        64'({e_act[m], e_hsel[m], e_trans[m], e_write[m], e_size[m], e_burst[m],
             e_prot[m], e_master[m], e_lock[m], e_rdy[m]}));
    chk({t, "_addr"}, {d_addr[m], d_auser[m]}, {e_addr[m], e_auser[m]});
    chk({t, "_data"}, {d_wdata[m], d_wuser[m]}, {e_wdata[m], e_wuser[m]});
  endtask

  // compare at negedge, advance model across the posedge, return at posedge+1
  task automatic tick();
    @(negedge HCLK);
    for (int m = 0; m < 2; m++) begin
      model_eval(m);
      cmp_model(m);
      model_next(m);
    end
    @(posedge HCLK);
    #1;
    for (int m = 0; m < 2; m++) begin
      m_own[m] = n_own[m]; m_last[m] = n_last[m]; m_dp[m] = n_dp[m];
      m_ssel[m] = n_ssel[m]; m_hl[m] = n_hl[m];
    end
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < N; p++) begin
      p_sel[p] = 1'b0; p_held[p] = 1'b0; p_write[p] = 1'b0; p_lock[p] = 1'b0;
      p_addr[p] = 32'h1000_0000 + 32'(p * 16); p_auser[p] = 32'(p);
      p_trans[p] = 2'b00; p_size[p] = 3'b010; p_burst[p] = 3'b000;
      p_prot[p] = 4'b0011; p_master[p] = 4'(p);
      p_wdata[p] = 32'hD000_0000 + 32'(p); p_wuser[p] = 32'hE000_0000 + 32'(p);
    end
    hreadyout = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 1'b0;
    model_reset();
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic req_port(input int p, input logic [1:0] tr);
    p_sel[p] = 1'b1; p_held[p] = 1'b1; p_trans[p] = tr;
  endtask

  task automatic randomize_inputs();
    for (int p = 0; p < N; p++) begin
      p_sel[p]    = ($urandom_range(0, 3) != 0);
      p_held[p]   = ($urandom_range(0, 2) != 0);
      p_trans[p]  = 2'($urandom_range(0, 3));
      p_write[p]  = 1'($urandom);
      p_lock[p]   = ($urandom_range(0, 5) == 0);
      p_size[p]   = 3'($urandom); p_burst[p] = 3'($urandom);
      p_prot[p]   = 4'($urandom); p_master[p] = 4'($urandom);
      p_addr[p]   = $urandom; p_auser[p] = $urandom;
      p_wdata[p]  = $urandom; p_wuser[p] = $urandom;
    end
    hreadyout = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    // reset with busy inputs: every output must still be at reset value
    randomize_inputs();
    for (int p = 0; p < N; p++) p_sel[p] = 1'b1;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk("reset_hsel", 64'(d_hsel[m]), 64'(0));
      chk("reset_trans", 64'(d_trans[m]), 64'(0));
      chk("reset_readymux", 64'(d_rdy[m]), 64'(1));
      chk("reset_active", 64'(d_act[m]), 64'(0));
      chk("reset_wdata", 64'(d_wdata[m]), 64'(0));
    end
    do_reset();

    // round-robin rotation over ports 0,2,3
    req_port(0, 2'b10); req_port(2, 2'b10); req_port(3, 2'b10);
    tick(); chk("rr_rot0", 64'(d_act[0]), 64'(4'b0001));
    chk("rr_rot0_hsel", 64'(d_hsel[0]), 64'(1));
    tick(); chk("rr_rot1", 64'(d_act[0]), 64'(4'b0100));
    tick(); chk("rr_rot2", 64'(d_act[0]), 64'(4'b1000));
    tick(); chk("rr_rot3", 64'(d_act[0]), 64'(4'b0001));

    // fixed priority: port 1 beats port 3 every cycle
    do_reset();
    req_port(1, 2'b10); req_port(3, 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("fx_prio", 64'(d_act[1]), 64'(4'b0010));
    end

    // INCR4 on port 2 holds off port 0
    do_reset();
    req_port(2, 2'b10); p_burst[2] = 3'b011;
    tick(); chk("burst_nseq", 64'(d_act[0]), 64'(4'b0100));
    chk("burst_trans", 64'(d_trans[0]), 64'(2'b10));
    tick(); chk("burst_beat0", 64'(d_act[0]), 64'(4'b0100));
    p_trans[2] = 2'b11; req_port(0, 2'b10);
    for (int i = 1; i <= 3; i++) begin
      tick(); chk("burst_hold", 64'(d_act[0]), 64'(4'b0100));
    end
    p_sel[2] = 1'b0; p_held[2] = 1'b0; p_trans[2] = 2'b00;
    tick(); chk("burst_next", 64'(d_act[0]), 64'(4'b0001));

    // locked sequence on port 1 with HSEL low mid-lock; port 3 waits
    do_reset();
    req_port(1, 2'b10); p_lock[1] = 1'b1; req_port(3, 2'b10);
    tick(); chk("lock_grant", 64'(d_act[0]), 64'(4'b0010));
    chk("lock_out", 64'(d_lock[0]), 64'(1));
    tick(); chk("lock_hold0", 64'(d_act[0]), 64'(4'b0010));
    p_sel[1] = 1'b0;
    tick(); chk("lock_hold_nosel", 64'(d_act[0]), 64'(4'b0010));
    chk("lock_nosel_hsel", 64'(d_hsel[0]), 64'(0));
    p_sel[1] = 1'b1; p_trans[1] = 2'b11;
    tick(); chk("lock_hold2", 64'(d_act[0]), 64'(4'b0010));
    p_lock[1] = 1'b0; p_trans[1] = 2'b10;
    tick(); chk("lock_release", 64'(d_act[0]), 64'(4'b1000));

    // wait states during a port 0 write
    do_reset();
    req_port(0, 2'b10); p_write[0] = 1'b1; p_wdata[0] = 32'hA5A5_0001;
    tick(); chk("ws_grant", 64'(d_act[0]), 64'(4'b0001));
    tick();
    p_sel[0] = 1'b0; p_held[0] = 1'b0; p_trans[0] = 2'b00;
    req_port(1, 2'b10); hreadyout = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk("ws_readymux", 64'(d_rdy[0]), 64'(0));
      chk("ws_wdata", 64'(d_wdata[0]), 64'(32'hA5A5_0001));
      chk("ws_frozen", 64'(d_act[0]), 64'(4'b0001));
    end
    hreadyout = 1'b1;
    tick(); chk("ws_after", 64'(d_act[0]), 64'(4'b0010));

    // randomized traffic with one asynchronous reset mid-run
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      randomize_inputs();
      if (c == 700) begin
        #2 HRESETn = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
          chk("async_rst_active", 64'(d_act[m]), 64'(0));
          chk("async_rst_hsel", 64'(d_hsel[m]), 64'(0));
          chk("async_rst_trans", 64'(d_trans[m]), 64'(0));
          chk("async_rst_readymux", 64'(d_rdy[m]), 64'(1));
          chk("async_rst_wdata", 64'(d_wdata[m]), 64'(0));
        end
        model_reset();
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
